// File: rtl/sm4_pkg.sv
// sm4_pkg: shared types and constants for the SM4 pipeline scheduler.
// Revision 1.0
`default_nettype none

package sm4_pkg;

  localparam int SM4_BLOCK_W      = 128;
  localparam int SM4_PIPE_LATENCY = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/sm4_rr_arbiter.sv
// sm4_rr_arbiter: single-winner round-robin arbiter, search starts after last_grant.
// Revision 1.0
`default_nettype none

module sm4_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand_idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // one extra bit so last_grant + k can wrap without overflow
      cand_sum = {1'b0, last_grant} + (ID_W + 1)'(k);
      if (cand_sum >= (ID_W + 1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
      end
      cand_idx = cand_sum[ID_W-1:0];
      if (en && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm4_pipe_scheduler.sv
// sm4_pipe_scheduler: shares one SM4 pipeline among NUM_REQ clients with
// bring-up sequencing, round-robin admission and owner-tagged result return.
`default_nettype none

module sm4_pipe_scheduler
  import sm4_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LATENCY = SM4_PIPE_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_enable_in,
  input  logic                           key_exp_ready_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*SM4_BLOCK_W-1:0] req_data_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [NUM_REQ-1:0]             rsp_valid_out,
  output logic [SM4_BLOCK_W-1:0]         rsp_data_out,
  output logic                           pipe_sm4_enable_out,
  output logic                           pipe_encdec_enable_out,
  output logic                           pipe_valid_out,
  output logic [SM4_BLOCK_W-1:0]         pipe_data_out,
  input  logic                           pipe_ready_in,
  input  logic [SM4_BLOCK_W-1:0]         pipe_result_in,
  output logic                           busy_out,
  output logic                           err_out
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t              state;
  logic                      arm_first;
  logic [ID_W-1:0]           last_grant;
  logic [ID_W-1:0]           grant_idx;
  logic                      accept;
  logic                      issue_v;
  logic [ID_W-1:0]           issue_id;
  logic [PIPE_LATENCY-1:0]   tag_v;
  logic [ID_W-1:0]           tag_id [PIPE_LATENCY];
  logic                      emerge_v;
  logic [ID_W-1:0]           emerge_id;
  logic [NUM_REQ-1:0]        emerge_onehot;
  logic [5:0]                in_flight;

  sm4_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid_in),
    .last_grant (last_grant),
    .en         (state == RUN),
    .grant      (req_ready_out),
    .grant_idx  (grant_idx)
  );

  assign accept                 = |(req_valid_in & req_ready_out);
  assign pipe_encdec_enable_out = (state != IDLE);
  assign busy_out               = (in_flight != 6'd0);
  assign emerge_v               = tag_v[PIPE_LATENCY-1];
  assign emerge_id              = tag_id[PIPE_LATENCY-1];

  always_comb begin
    emerge_onehot            = '0;
    emerge_onehot[emerge_id] = 1'b1;
  end

  // arm_first blocks ARM->RUN on the first ARM cycle so the pipeline settles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      arm_first           <= 1'b0;
      pipe_sm4_enable_out <= 1'b0;
    end else begin
      pipe_sm4_enable_out <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_enable_in) begin
            state     <= ARM;
            arm_first <= 1'b1;
          end
        end
        ARM: begin
          arm_first <= 1'b0;
          if (!cfg_enable_in) begin
            state <= IDLE;
          end else if (key_exp_ready_in && !arm_first) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!cfg_enable_in || !key_exp_ready_in) state <= DRAIN;
        end
        DRAIN: begin
          if (in_flight == 6'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid_out <= 1'b0;
      pipe_data_out  <= '0;
      issue_v        <= 1'b0;
      issue_id       <= '0;
      last_grant     <= ID_W'(NUM_REQ - 1);
      rsp_valid_out  <= '0;
      rsp_data_out   <= '0;
      in_flight      <= 6'd0;
      err_out        <= 1'b0;
    end else begin
      pipe_valid_out <= accept;
      issue_v        <= accept;
      if (accept) begin
        pipe_data_out <= req_data_in[int'(grant_idx)*SM4_BLOCK_W +: SM4_BLOCK_W];
        issue_id      <= grant_idx;
        last_grant    <= grant_idx;
      end
      rsp_valid_out <= (emerge_v && pipe_ready_in) ? emerge_onehot : '0;
      if (emerge_v && pipe_ready_in) rsp_data_out <= pipe_result_in;
      case ({accept, emerge_v})
        2'b10:   in_flight <= in_flight + 6'd1;
        2'b01:   in_flight <= in_flight - 6'd1;
        default: in_flight <= in_flight;
      endcase
      if (emerge_v != pipe_ready_in) err_out <= 1'b1;
    end
  end

  // issue tag sits beside pipe_valid_out; this line adds PIPE_LATENCY more stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[PIPE_LATENCY-2:0], issue_v};
      tag_id[0] <= issue_id;
      for (int i = 1; i < PIPE_LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm4_pipe_scheduler.sv
// tb_sm4_pipe_scheduler: directed bench with a delay-line pipeline stand-in and owner scoreboard.
`default_nettype none

module tb_sm4_pipe_scheduler;

  localparam int N   = 4;
  localparam int L   = 32;
  localparam int BW  = 128;
  localparam int LAT = L + 2;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_enable_in;
  logic             key_exp_ready_in;
  logic [N-1:0]     req_valid_in;
  logic [N*BW-1:0]  req_data_in;
  logic [N-1:0]     req_ready_out;
  logic [N-1:0]     rsp_valid_out;
  logic [BW-1:0]    rsp_data_out;
  logic             pipe_sm4_enable_out;
  logic             pipe_encdec_enable_out;
  logic             pipe_valid_out;
  logic [BW-1:0]    pipe_data_out;
  logic             pipe_ready_in;
  logic [BW-1:0]    pipe_result_in;
  logic             busy_out;
  logic             err_out;

  sm4_pipe_scheduler #(.NUM_REQ(N), .PIPE_LATENCY(L)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .cfg_enable_in          (cfg_enable_in),
    .key_exp_ready_in       (key_exp_ready_in),
    .req_valid_in           (req_valid_in),
    .req_data_in            (req_data_in),
    .req_ready_out          (req_ready_out),
    .rsp_valid_out          (rsp_valid_out),
    .rsp_data_out           (rsp_data_out),
    .pipe_sm4_enable_out    (pipe_sm4_enable_out),
    .pipe_encdec_enable_out (pipe_encdec_enable_out),
    .pipe_valid_out         (pipe_valid_out),
    .pipe_data_out          (pipe_data_out),
    .pipe_ready_in          (pipe_ready_in),
    .pipe_result_in         (pipe_result_in),
    .busy_out               (busy_out),
    .err_out                (err_out)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the published vector maps to its ciphertext, anything else to a reversible scramble.
  function automatic logic [127:0] cipher(input logic [127:0] d);
    if (d == PT) return CT;
    return {d[63:0], d[127:64]} ^ 128'hc3c3_5a5a_0ff0_1234_a5a5_3c3c_f00f_4321;
  endfunction

  function automatic logic [127:0] mkdata(input int id, input int s);
    return {id, s, 64'hfeed_face_0bad_f00d};
  endfunction

  // Pipeline model: result appears L cycles after pipe_valid_out is sampled.
  logic [L-1:0]  pm_v;
  logic [BW-1:0] pm_d [L];
  logic          force_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pm_v <= '0;
      for (int i = 0; i < L; i++) pm_d[i] <= '0;
    end else begin
      pm_v    <= {pm_v[L-2:0], pipe_valid_out};
      pm_d[0] <= cipher(pipe_data_out);
      for (int i = 1; i < L; i++) pm_d[i] <= pm_d[i-1];
    end
  end
  assign pipe_ready_in  = pm_v[L-1] | force_ready;
  assign pipe_result_in = pm_d[L-1];

  // Requester drive
  int           quota [N];
  logic [BW-1:0] blk  [N];
  int           seq   [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign req_data_in[gi*BW +: BW] = blk[gi];
    assign req_valid_in[gi]         = (quota[gi] != 0);
  end

  typedef struct {
    int            id;
    logic [127:0]  exp;
    int            cyc;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_rr = 0;
  bit rr_chk = 1'b0;
  int no_grant_from = 1 << 30;
  int bad_grants = 0;
  int drop_cyc = -1;
  bit drop_acc = 1'b0;
  bit acc_seen;
  int acc_total = 0;
  int last_acc_cyc = 0;
  logic [N-1:0]  last_rsp_vec;
  logic [BW-1:0] last_rsp_data;
  int            last_rsp_lat;
  logic obs_busy, obs_encdec, obs_err, obs_sm4;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: observe at negedge, then update drive just after the rising edge.
  task automatic tick();
    int  aid;
    sb_t e;
    @(negedge clk);
    cyc++;
    aid        = -1;
    acc_seen   = 1'b0;
    obs_busy   = busy_out;
    obs_encdec = pipe_encdec_enable_out;
    obs_err    = err_out;
    obs_sm4    = pipe_sm4_enable_out;
    check("grant_onehot", 128'($countones(req_ready_out) <= 1), 1);
    check("grant_valid", req_ready_out & ~req_valid_in, 0);
    for (int i = 0; i < N; i++) begin
      if (req_valid_in[i] && req_ready_out[i]) aid = i;
    end
    if (aid >= 0) begin
      acc_seen     = 1'b1;
      acc_total++;
      last_acc_cyc = cyc;
      sb.push_back('{id: aid, exp: cipher(blk[aid]), cyc: cyc});
      if (rr_chk) check("rr_order", aid, exp_rr);
      exp_rr = (aid + 1) % N;
      if (cyc >= no_grant_from) bad_grants++;
      if (cyc == drop_cyc) drop_acc = 1'b1;
    end
    if (rsp_valid_out != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", rsp_valid_out, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", rsp_valid_out, 4'b0001 << e.id);
        check("rsp_data", rsp_data_out, e.exp);
        check("rsp_latency", cyc - e.cyc, LAT);
        last_rsp_vec  = rsp_valid_out;
        last_rsp_data = rsp_data_out;
        last_rsp_lat  = cyc - e.cyc;
      end
    end
    @(posedge clk);
    #1;
    if (aid >= 0) begin
      seq[aid]++;
      blk[aid] = mkdata(aid, seq[aid]);
      if (quota[aid] > 0) quota[aid]--;
    end
  endtask

  task automatic set_quota(input int q);
    for (int i = 0; i < N; i++) quota[i] = q;
  endtask

  task automatic wait_idle_busy(input string tag);
    int n = 0;
    obs_busy = 1'b1;
    while (obs_busy && n < 120) begin
      tick();
      n++;
    end
    check(tag, obs_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int acc0;
    reset_n          = 1'b0;
    cfg_enable_in    = 1'b0;
    key_exp_ready_in = 1'b0;
    force_ready      = 1'b0;
    for (int i = 0; i < N; i++) begin
      quota[i] = 0;
      seq[i]   = 0;
      blk[i]   = mkdata(i, 0);
    end

    // Reset state
    repeat (3) tick();
    check("rst_ctl", {req_ready_out, rsp_valid_out, pipe_sm4_enable_out, pipe_encdec_enable_out,
                      pipe_valid_out, busy_out, err_out}, 0);
    check("rst_pipe_data", pipe_data_out, 0);
    check("rst_rsp_data", rsp_data_out, 0);
    reset_n = 1'b1;
    tick();
    check("sm4_en_before_edge", obs_sm4, 0);
    tick();
    check("sm4_en_after_edge", obs_sm4, 1);
    check("encdec_idle", obs_encdec, 0);

    // Single client, key already ready when cfg rises
    blk[0]           = PT;
    quota[0]         = 1;
    cfg_enable_in    = 1'b1;
    key_exp_ready_in = 1'b1;
    c0 = cyc + 1;
    n  = 0;
    acc0 = acc_total;
    while (acc_total == acc0 && n < 20) begin
      tick();
      n++;
    end
    check("first_grant_offset", last_acc_cyc - c0, 3);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("single_drained", sb.size(), 0);
    check("single_rsp_vec", last_rsp_vec, 4'b0001);
    check("single_rsp_data", last_rsp_data, CT);
    check("single_rsp_lat", last_rsp_lat, 34);
    check("single_no_err", err_out, 0);

    // All four requesters continuously valid for 40 cycles
    rr_chk = 1'b1;
    set_quota(-1);
    acc0 = acc_total;
    repeat (40) tick();
    set_quota(0);
    rr_chk = 1'b0;
    check("all4_accepts", acc_total - acc0, 40);
    wait_idle_busy("all4_busy_timeout");
    check("all4_busy_fall", cyc - last_acc_cyc, 34);
    check("all4_drained", sb.size(), 0);

    // Key drop with blocks in flight
    set_quota(-1);
    repeat (10) tick();
    key_exp_ready_in = 1'b0;
    drop_cyc      = cyc + 1;
    no_grant_from = cyc + 2;
    bad_grants    = 0;
    n = 0;
    obs_encdec = 1'b1;
    while (obs_encdec && n < 80) begin
      tick();
      n++;
    end
    check("drop_reached_idle", obs_encdec, 0);
    check("drop_cycle_grant", drop_acc, 1);
    check("drop_no_new_grants", bad_grants, 0);
    check("drop_all_rsp", sb.size(), 0);
    no_grant_from    = 1 << 30;
    key_exp_ready_in = 1'b1;
    acc0 = acc_total;
    n = 0;
    while (acc_total == acc0 && n < 10) begin
      tick();
      n++;
    end
    check("resume_grant", acc_total > acc0, 1);
    set_quota(0);
    wait_idle_busy("resume_busy_timeout");
    check("resume_drained", sb.size(), 0);
    check("resume_no_err", err_out, 0);

    // Ready with no block issued
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("err_sticky", obs_err, 1);
    end

    // Asynchronous reset with blocks in flight
    set_quota(-1);
    repeat (20) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ctl", {req_ready_out, rsp_valid_out, pipe_sm4_enable_out, pipe_encdec_enable_out,
                       pipe_valid_out, busy_out, err_out}, 0);
    check("arst_pipe_data", pipe_data_out, 0);
    check("arst_rsp_data", rsp_data_out, 0);
    sb.delete();
    set_quota(0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (50) tick();
    check("post_rst_busy", obs_busy, 0);
    check("post_rst_err", obs_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
